// File: rtl/demux16_collector.sv
// demux16_collector: routes one serial bit per cycle into the addressed lane of a
// frame register and offers the completed frame on a valid/ready handshake.
module demux16_collector #(
  parameter  int SEL_W = 4,
  localparam int LANES = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic [SEL_W-1:0] sel,
  input  logic             wr_en,
  input  logic             clear,
  output logic [LANES-1:0] frame,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [LANES-1:0] seen,
  output logic [SEL_W:0]   count,
  output logic             overrun
);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

  localparam logic [SEL_W:0] COUNT_ONE  = (SEL_W+1)'(1);
  localparam logic [SEL_W:0] COUNT_LAST = (SEL_W+1)'(LANES - 1);

  state_t             state_r;
  logic [LANES-1:0]   frame_r;
  logic [LANES-1:0]   seen_r;
  logic [SEL_W:0]     count_r;
  logic               overrun_r;

  assign frame       = frame_r;
  assign seen        = seen_r;
  assign count       = count_r;
  assign overrun     = overrun_r;
  assign frame_valid = (state_r == ST_HOLD);

  // Collect/hold state machine; clear outranks both writes and the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_COLLECT;
      frame_r   <= '0;
      seen_r    <= '0;
      count_r   <= '0;
      overrun_r <= 1'b0;
    end else if (clear) begin
      state_r   <= ST_COLLECT;
      seen_r    <= '0;
      count_r   <= '0;
      overrun_r <= 1'b0;
    end else begin
      case (state_r)
        ST_COLLECT: begin
          if (wr_en) begin
            frame_r[sel] <= din;
            seen_r[sel]  <= 1'b1;
            // Only a first write to a lane advances the count; the last new lane completes the frame.
            if (!seen_r[sel]) begin
              count_r <= count_r + COUNT_ONE;
              if (count_r == COUNT_LAST) begin
                state_r <= ST_HOLD;
              end
            end
          end
        end
        ST_HOLD: begin
          if (wr_en) begin
            overrun_r <= 1'b1;
          end
          if (frame_ready) begin
            state_r <= ST_COLLECT;
            seen_r  <= '0;
            count_r <= '0;
          end
        end
        default: begin
          state_r <= ST_COLLECT;
          seen_r  <= '0;
          count_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux16_collector.sv
// Scoreboard bench for demux16_collector: a lane-set reference model predicts every
// cycle's outputs and queues completed frames for a handshake monitor.
module tb_demux16_collector;
  localparam int LANES = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic        wr_en = 1'b0;
  logic        clear = 1'b0;
  logic        frame_ready = 1'b0;
  logic [15:0] frame;
  logic        frame_valid;
  logic [15:0] seen;
  logic [4:0]  count;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  bit          m_seen [LANES];
  logic [15:0] m_frame;
  bit          m_hold;
  bit          m_ovr;
  logic [15:0] expq [$];

  always #5 clk = ~clk;

  demux16_collector #(.SEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .wr_en(wr_en), .clear(clear),
    .frame(frame), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .seen(seen), .count(count), .overrun(overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < LANES; i++) n += int'(m_seen[i]);
    return n;
  endfunction

  function automatic logic [15:0] m_seen_vec();
    logic [15:0] v = 16'h0000;
    for (int i = 0; i < LANES; i++) v[i] = m_seen[i];
    return v;
  endfunction

  task automatic m_forget_lanes();
    for (int i = 0; i < LANES; i++) m_seen[i] = 1'b0;
  endtask

  task automatic model_reset();
    m_forget_lanes();
    m_frame = 16'h0000;
    m_hold  = 1'b0;
    m_ovr   = 1'b0;
    expq.delete();
  endtask

  // Applies the block's rules to the inputs sampled at the edge just taken.
  task automatic model_edge();
    if (clear) begin
      if (m_hold) void'(expq.pop_back());
      m_forget_lanes();
      m_hold = 1'b0;
      m_ovr  = 1'b0;
    end else if (m_hold) begin
      if (wr_en) m_ovr = 1'b1;
      if (frame_ready) begin
        m_hold = 1'b0;
        m_forget_lanes();
      end
    end else if (wr_en) begin
      m_frame[sel] = din;
      m_seen[sel]  = 1'b1;
      if (m_count() == LANES) begin
        m_hold = 1'b1;
        expq.push_back(m_frame);
      end
    end
  endtask

  task automatic check_outputs();
    check("frame", frame, m_frame);
    check("seen", seen, m_seen_vec());
    check("count", count, m_count());
    check("overrun", overrun, m_ovr);
    check("frame_valid", frame_valid, m_hold);
  endtask

  task automatic cycle(input bit wr, input logic [3:0] s, input bit d, input bit rdy, input bit clr);
    wr_en = wr; sel = s; din = d; frame_ready = rdy; clear = clr;
    @(posedge clk);
    model_edge();
    #1 check_outputs();
  endtask

  // Handshake monitor: a frame is consumed at the coming edge, so compare it against the queue now.
  always @(negedge clk) begin
    if (rst_n && frame_valid && frame_ready && !clear) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL handshake_unexpected: got frame %0h expected no frame", frame);
      end else begin
        check("handshake_frame", frame, expq.pop_front());
      end
    end
  end

  initial begin
    logic [15:0] pat;
    model_reset();
    #12;
    check("reset_frame", frame, 16'h0000);
    check("reset_valid", frame_valid, 1'b0);
    check("reset_count", count, 5'd0);
    @(negedge clk) rst_n = 1'b1;

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
    check("pre_reset_count", count, 5'd5);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_frame", frame, 16'h0000);
    check("async_seen", seen, 16'h0000);
    check("async_count", count, 5'd0);
    check("async_valid", frame_valid, 1'b0);
    check("async_overrun", overrun, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // Full in-order sweep with the consumer always ready.
    for (int i = 0; i < LANES; i++) cycle(1'b1, 4'(i), i[0], 1'b1, 1'b0);
    check("sweep_frame", frame, 16'hAAAA);
    check("sweep_valid", frame_valid, 1'b1);
    cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    check("sweep_valid_drop", frame_valid, 1'b0);
    check("sweep_count_zero", count, 5'd0);

    // Descending lanes with a repeated lane 3 before the final lane.
    for (int i = 15; i >= 1; i--) cycle(1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    check("dup_count", count, 5'd15);
    check("dup_not_valid", frame_valid, 1'b0);
    cycle(1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    check("dup_count_full", count, 5'd16);
    check("dup_frame", frame, 16'hFFF7);
    cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

    // Backpressure with writes dropped during the stall.
    pat = 16'h1234;
    for (int i = 0; i < LANES; i++) cycle(1'b1, 4'(i), pat[i], 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cycle(k < 2, 4'(k + 5), 1'b1, 1'b0, 1'b0);
    check("stall_frame", frame, 16'h1234);
    check("stall_overrun", overrun, 1'b1);
    check("stall_valid", frame_valid, 1'b1);
    cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    check("stall_release_valid", frame_valid, 1'b0);
    check("overrun_sticky", overrun, 1'b1);

    // Clear together with a write after nine lanes.
    for (int i = 0; i < 9; i++) cycle(1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 4'd9, 1'b0, 1'b0, 1'b1);
    check("clear_count", count, 5'd0);
    check("clear_seen", seen, 16'h0000);
    check("clear_overrun", overrun, 1'b0);
    check("clear_write_ignored", frame[9], 1'b1);
    for (int i = 0; i < 15; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
    check("clear_needs_16", frame_valid, 1'b0);
    cycle(1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
    check("clear_then_full", frame_valid, 1'b1);

    // Write to lane 0 in the handshake cycle.
    cycle(1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
    check("collide_overrun", overrun, 1'b1);
    check("collide_seen", seen, 16'h0000);
    check("collide_frame", frame, 16'h0000);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom % 4) != 0, 4'($urandom % 16), 1'($urandom % 2),
            ($urandom % 3) == 0, ($urandom % 50) == 0);
    end

    cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    check("queue_drained", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
